// File: rtl/dbus_pkg.sv
// Shared types and defaults for the data-side bus bridge.
// The state enum, width helpers and reset-time defaults are used by the bridge and its timeout counter.
package dbus_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam logic [31:0] ERR_RDATA_DEF = 32'h0;

  function automatic int unsigned be_w(input int unsigned dw);
    return dw / 8;
  endfunction

  // Width must hold the value TIMEOUT_CYC itself; a disabled timeout still needs a legal vector.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dbus_if.sv
// SoC data bus: req/gnt request phase and rvalid response phase.
// The bridge drives the bus through the master modport; RAM and peripherals sit on the slave side.
interface dbus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  bus_req;
  logic                  bus_gnt;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_be;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/dbus_timeout_ctr.sv
// Access timeout counter: cleared when a transaction is launched, counts busy cycles.
// o_expire fires during the TIMEOUT_CYC-th busy cycle so the FSM leaves on the following edge.
module dbus_timeout_ctr
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int unsigned CW = cnt_w(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (TIMEOUT_CYC != 0) && i_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dbus_bridge.sv
// Data-side bus master: turns the MEM stage's single-cycle access into one outstanding
// req/gnt/rvalid transaction and stalls the pipeline until it completes.
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(ERR_RDATA_DEF)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_ce_i,
  input  logic                   core_we_i,
  input  logic [ADDR_W-1:0]      core_addr_i,
  input  logic [DATA_W-1:0]      core_wdata_i,
  input  logic [DATA_W/8-1:0]    core_be_i,
  output logic [DATA_W-1:0]      core_rdata_o,
  output logic                   core_err_o,
  output logic                   core_stallreq_o,
  dbus_if.master                 bus
);
  localparam int unsigned BE_W = be_w(DATA_W);

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_start, w_busy, w_resp, w_expire, w_to, w_fin;

  function automatic logic [DATA_W-1:0] resp_data(input logic we, input logic err,
                                                  input logic [DATA_W-1:0] rdata);
    if (err)     return ERR_RDATA;
    else if (we) return '0;
    else         return rdata;
  endfunction

  // Reset gating keeps the combinational stall low while the async reset is held.
  assign w_start = (r_state == IDLE) && core_ce_i && (|core_be_i) && !rst_i;
  assign w_busy  = (r_state == REQ) || (r_state == WAIT);
  assign w_resp  = bus.bus_rvalid && ((r_state == WAIT) || ((r_state == REQ) && bus.bus_gnt));
  assign w_to    = w_expire && !w_resp;
  assign w_fin   = w_busy && (w_resp || w_to);

  dbus_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clr    (w_start),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = REQ;
      REQ:     if (w_fin) w_next = DONE;
               else if (bus.bus_gnt) w_next = WAIT;
      WAIT:    if (w_fin) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_we    <= core_we_i;
        r_addr  <= core_addr_i;
        r_wdata <= core_wdata_i;
        r_be    <= core_be_i;
      end
      // A timeout completes with an error even if a stray bus_err is sampled without rvalid.
      if (w_fin) begin
        r_err   <= w_to || (w_resp && bus.bus_err);
        r_rdata <= resp_data(r_we, w_to || (w_resp && bus.bus_err), bus.bus_rdata);
      end
    end
  end

  assign bus.bus_req   = (r_state == REQ);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr & ~ADDR_W'(3);
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_be    = r_be;

  assign core_rdata_o    = r_rdata;
  assign core_err_o      = (r_state == DONE) && r_err;
  assign core_stallreq_o = w_start || w_busy;

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: stimulus pushes expected completions and bus requests into
// queues; independent negedge monitors pop and compare when the DUT completes or is granted.
module tb_dbus_bridge;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_ce = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [3:0]  core_be = '0;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        core_stall;

  always #5 clk = ~clk;

  dbus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dbus_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .ERR_RDATA(ERRD)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .core_ce_i       (core_ce),
    .core_we_i       (core_we),
    .core_addr_i     (core_addr),
    .core_wdata_i    (core_wdata),
    .core_be_i       (core_be),
    .core_rdata_o    (core_rdata),
    .core_err_o      (core_err),
    .core_stallreq_o (core_stall),
    .bus             (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } core_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_exp_t;

  core_exp_t core_q[$];
  bus_exp_t  bus_q[$];
  bus_exp_t  cur;
  int        n_chk = 0;
  int        n_err = 0;
  int        stall_cnt;
  int        req_cnt;
  logic      prev_stall = 1'b0;
  logic      chk_err_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Completion monitor: a stall falling edge outside reset marks the DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall   <= 1'b0;
      chk_err_next <= 1'b0;
    end else begin
      if (chk_err_next) chk("err_pulse_len", {31'b0, core_err}, 32'd0);
      chk_err_next <= 1'b0;
      if (prev_stall && !core_stall) begin
        chk("done_expected", 32'(core_q.size() != 0), 32'd1);
        if (core_q.size() != 0) begin
          chk("done_rdata", core_rdata, core_q[0].rdata);
          chk("done_err", {31'b0, core_err}, {31'b0, core_q[0].err});
          chk("done_no_req", {31'b0, bus.bus_req}, 32'd0);
          void'(core_q.pop_front());
          chk_err_next <= 1'b1;
        end
      end
      prev_stall <= core_stall;
    end
  end

  // Bus monitor: every accepted request must match the next expected transaction.
  always @(negedge clk) begin
    if (!rst && bus.bus_req && bus.bus_gnt) begin
      chk("acc_expected", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0) begin
        chk("acc_we", {31'b0, bus.bus_we}, {31'b0, bus_q[0].we});
        chk("acc_addr", bus.bus_addr, bus_q[0].addr);
        chk("acc_wdata", bus.bus_wdata, bus_q[0].wdata);
        chk("acc_be", {28'b0, bus.bus_be}, {28'b0, bus_q[0].be});
        void'(bus_q.pop_front());
      end
    end
  end

  task automatic samp();
    if (core_stall) stall_cnt++;
    if (bus.bus_req) begin
      req_cnt++;
      chk("req_addr", bus.bus_addr, cur.addr);
      chk("req_be", {28'b0, bus.bus_be}, {28'b0, cur.be});
      chk("req_wdata", bus.bus_wdata, cur.wdata);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int gw, input int rw,
                        input logic [31:0] rdata, input logic berr,
                        input logic [31:0] exp_addr, input logic [31:0] exp_rd,
                        input int exp_stall);
    bus_exp_t  b;
    core_exp_t c;
    b.we = we; b.addr = exp_addr; b.wdata = wdata; b.be = be;
    c.rdata = exp_rd; c.err = berr;
    bus_q.push_back(b);
    core_q.push_back(c);
    cur = b; stall_cnt = 0; req_cnt = 0;
    core_ce = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_be = be;
    mid();
    chk("stall_comb", {31'b0, core_stall}, 32'd1);
    chk("req_in_idle", {31'b0, bus.bus_req}, 32'd0);
    cyc();
    for (int i = 0; i < gw; i++) begin
      bus.bus_gnt = 1'b0; bus.bus_rvalid = (i == 0); bus.bus_rdata = 32'h5A5A_5A5A;
      mid(); samp(); cyc();
    end
    bus.bus_gnt = 1'b1; bus.bus_rvalid = (rw == 0); bus.bus_rdata = rdata; bus.bus_err = berr;
    mid(); samp(); cyc();
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_err = 1'b0;
    if (rw > 0) begin
      for (int j = 1; j < rw; j++) begin
        mid(); samp(); cyc();
      end
      bus.bus_rvalid = 1'b1; bus.bus_rdata = rdata; bus.bus_err = berr;
      mid(); samp(); cyc();
      bus.bus_rvalid = 1'b0; bus.bus_err = 1'b0;
    end
    mid();
    chk("stall_cycles", stall_cnt, exp_stall);
    chk("req_cycles", req_cnt, gw + 1);
    cyc();
    core_ce = 1'b0; core_be = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core_exp_t c;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0; bus.bus_err = 1'b0;

    repeat (3) cyc();
    mid();
    chk("rst_stall", {31'b0, core_stall}, 32'd0);
    chk("rst_req", {31'b0, bus.bus_req}, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_err", {31'b0, core_err}, 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    chk("rst_we_be", {27'b0, bus.bus_we, bus.bus_be}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // zero-wait load
    access(1'b0, 32'h104, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 1'b0, 32'h104, 32'hCAFE_F00D, 1);
    cyc();
    // store with 3 grant waits and 2 response waits
    access(1'b1, 32'h203, 32'hAB00_0000, 4'h8, 3, 2, 32'h1111_1111, 1'b0, 32'h200, 32'h0, 6);
    cyc();
    // bus error on a load
    access(1'b0, 32'h300, 32'h0, 4'hF, 1, 1, 32'h1234_5678, 1'b1, 32'h300, ERRD, 3);
    cyc();

    // timeout: never granted
    c.rdata = ERRD; c.err = 1'b1;
    core_q.push_back(c);
    cur.we = 1'b0; cur.addr = 32'h400; cur.wdata = 32'h0; cur.be = 4'hF;
    stall_cnt = 0; req_cnt = 0;
    core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h400; core_wdata = '0; core_be = 4'hF;
    mid(); cyc();
    for (int i = 0; i < TO; i++) begin
      mid(); samp(); cyc();
    end
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h5555_5555;
    mid();
    chk("to_stall_cycles", stall_cnt, TO);
    chk("to_req_cycles", req_cnt, TO);
    cyc();
    core_ce = 1'b0; core_be = '0;
    mid();
    chk("late_rv_stall", {31'b0, core_stall}, 32'd0);
    chk("late_rv_req", {31'b0, bus.bus_req}, 32'd0);
    chk("rdata_hold", core_rdata, ERRD);
    cyc();
    bus.bus_rvalid = 1'b0;
    cyc();

    // be==0: no transaction, no stall
    core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h700; core_be = 4'h0;
    mid();
    chk("be0_stall", {31'b0, core_stall}, 32'd0);
    chk("be0_req", {31'b0, bus.bus_req}, 32'd0);
    cyc(); mid();
    chk("be0_req_next", {31'b0, bus.bus_req}, 32'd0);
    cyc();
    core_ce = 1'b0;
    cyc();

    // back-to-back loads
    access(1'b0, 32'h010, 32'h0, 4'hF, 0, 1, 32'h0000_1111, 1'b0, 32'h010, 32'h0000_1111, 2);
    access(1'b0, 32'h016, 32'h0, 4'h3, 0, 0, 32'h2222_0000, 1'b0, 32'h014, 32'h2222_0000, 1);
    cyc();

    // async reset while waiting for the response
    cur.we = 1'b0; cur.addr = 32'h500; cur.wdata = 32'h0; cur.be = 4'hF;
    bus_q.push_back(cur);
    core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h500; core_wdata = '0; core_be = 4'hF;
    mid(); cyc();
    bus.bus_gnt = 1'b1;
    mid(); cyc();
    bus.bus_gnt = 1'b0;
    mid();
    chk("wait_stall", {31'b0, core_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", {31'b0, core_stall}, 32'd0);
    chk("arst_req", {31'b0, bus.bus_req}, 32'd0);
    chk("arst_addr", bus.bus_addr, 32'd0);
    chk("arst_rdata", core_rdata, 32'd0);
    cyc(); cyc();
    rst = 1'b0; core_ce = 1'b0; core_be = '0;
    mid();
    chk("post_rst_stall", {31'b0, core_stall}, 32'd0);
    cyc();
    access(1'b0, 32'h600, 32'h0, 4'hF, 1, 0, 32'h600D_600D, 1'b0, 32'h600, 32'h600D_600D, 2);

    repeat (3) cyc();
    chk("core_q_empty", core_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
